// File: rtl/response_checker.sv
// In-order response checker: expected beats are queued in a FIFO and compared
// against DUT output beats, reporting counts, first failure and a pass verdict.
module response_checker #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_ready,
    input  logic             act_valid,
    input  logic [WIDTH-1:0] act_data,
    output logic             act_ready,
    output logic             err_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act,
    output logic             unexpected,
    output logic             missing,
    output logic             done,
    output logic             pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_after;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] beat_idx;
    logic [WIDTH-1:0] head;
    logic             empty, full, act_beat, push, pop, fail;
    logic             start_run, drain_timeout;

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign head        = mem[rd_ptr];
    assign act_ready   = (state == RUN) || (state == DRAIN);
    assign act_beat    = act_valid && act_ready;
    // A full FIFO still accepts a push when the same cycle pops the head.
    assign exp_ready   = (state == RUN) && (!full || act_beat);
    assign push        = exp_valid && exp_ready;
    assign pop         = act_beat && !empty;
    assign fail        = act_beat && (empty || (head != act_data));
    assign count_after = count + (AW+1)'(push) - (AW+1)'(pop);
    assign start_run   = start && ((state == IDLE) || (state == DONE));
    assign done        = (state == DONE);
    assign pass        = done && (mismatch_cnt == '0) && !unexpected && !missing;

    always_comb begin
        state_next    = state;
        drain_timeout = 1'b0;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (finish) state_next = DRAIN;
            DRAIN: begin
                if (empty) begin
                    state_next = DONE;
                end else if (drain_cnt == DW'(TIMEOUT - 1)) begin
                    state_next    = DONE;
                    drain_timeout = 1'b1;
                end
            end
            DONE:  if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start_run) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_after;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 drain_cnt <= '0;
        else if (state != DRAIN) drain_cnt <= '0;
        else                     drain_cnt <= drain_cnt + DW'(1);
    end

    // Scoreboard results; a zero mismatch count marks that no failure was captured yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || start_run) begin
            err_pulse     <= 1'b0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            beat_idx      <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
            unexpected    <= 1'b0;
            missing       <= 1'b0;
        end else begin
            err_pulse <= fail;
            if (act_beat) beat_idx <= beat_idx + CNT_W'(1);
            if (act_beat && !fail && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
            if (fail) begin
                if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                if (mismatch_cnt == '0) begin
                    first_err_idx <= beat_idx;
                    first_err_exp <= empty ? '0 : head;
                    first_err_act <= act_data;
                end
            end
            if (act_beat && empty) unexpected <= 1'b1;
            if (drain_timeout && (count_after != '0)) missing <= 1'b1;
        end
    end

endmodule
